// File: rtl/decode_pkg.sv
// decode_pkg: widths, opcode constants and instruction field positions shared by
// fetch, decode and execute, plus the decoded-instruction record type.
// Optional DECODE_ILLEGAL_TRAP_EN adds the 'illegal' member to dec_t.
package decode_pkg;

  localparam int RW     = 16;  // machine word / PC width
  localparam int I_SIZE = 32;  // instruction width
  localparam int RSEL   = 3;   // register-select width (8 GPRs)
  localparam int OPC_W  = 7;
  localparam int COND_W = 4;

  // Field bit positions inside an instruction
  localparam int OPC_LSB  = 0;
  localparam int RD_LSB   = 7;
  localparam int RS1_LSB  = 10;
  localparam int RS2_LSB  = 13;
  localparam int COND_LSB = 7;   // condition overlaps rd and the low bit of rs1
  localparam int IMM_LSB  = 16;

  localparam logic [OPC_W-1:0] OP_NOP    = 7'h00;
  localparam logic [OPC_W-1:0] OP_ALU_LO = 7'h01;
  localparam logic [OPC_W-1:0] OP_ALU_HI = 7'h0d;
  localparam logic [OPC_W-1:0] OP_JMP    = 7'h0e;
  localparam logic [OPC_W-1:0] OP_CALL   = 7'h0f;
  localparam logic [OPC_W-1:0] OP_LD     = 7'h10;
  localparam logic [OPC_W-1:0] OP_ST     = 7'h11;
  localparam logic [OPC_W-1:0] OP_SRS    = 7'h12;

  typedef enum logic [1:0] {
    ST_EMPTY,  // nothing presented to execute
    ST_FULL,   // output slot holds an instruction, skid empty
    ST_SKID    // output slot and skid both hold instructions
  } slot_state_t;

  typedef struct packed {
    logic [RW-1:0]     pc;
    logic [OPC_W-1:0]  opcode;
    logic [RSEL-1:0]   rd;
    logic [RSEL-1:0]   rs1;
    logic [RSEL-1:0]   rs2;
    logic [COND_W-1:0] cond;
    logic [RW-1:0]     imm;
    logic              reg_we;
    logic              mem_rd;
    logic              mem_wr;
    logic              jump;
    logic              jmp_predict;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic              illegal;
`endif
  } dec_t;

endpackage

// File: rtl/decode_comb.sv
// decode_comb: instruction -> fields/controls, tagged with its PC and prediction bit.
// Latency: purely combinational. Backpressure: none, caller decides where to load it.
// Ports: instr/pc/jmp_predict in; dec (dec_t) out. DECODE_ILLEGAL_TRAP_EN flags undefined opcodes.
module decode_comb
  import decode_pkg::*;
(
  input  logic [I_SIZE-1:0] instr,
  input  logic [RW-1:0]     pc,
  input  logic              jmp_predict,
  output dec_t              dec
);

  logic [OPC_W-1:0] opc;
  assign opc = instr[OPC_LSB +: OPC_W];

  always_comb begin
    dec             = '0;
    dec.pc          = pc;
    dec.opcode      = opc;
    dec.rd          = instr[RD_LSB   +: RSEL];
    dec.rs1         = instr[RS1_LSB  +: RSEL];
    dec.rs2         = instr[RS2_LSB  +: RSEL];
    dec.cond        = instr[COND_LSB +: COND_W];
    dec.imm         = instr[IMM_LSB  +: RW];
    dec.jmp_predict = jmp_predict;

    case (opc)
      OP_NOP:  ;
      OP_JMP:  dec.jump = 1'b1;
      OP_CALL: begin
        dec.jump   = 1'b1;
        dec.reg_we = 1'b1;
      end
      OP_LD: begin
        dec.reg_we = 1'b1;
        dec.mem_rd = 1'b1;
      end
      OP_ST:   dec.mem_wr = 1'b1;
      OP_SRS:  dec.reg_we = 1'b1;
      default: begin
        if (opc >= OP_ALU_LO && opc <= OP_ALU_HI) dec.reg_we = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
        else dec.illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/decode.sv
// decode: instruction decode stage between fetch and execute, with PC tracking.
// Latency: 1 cycle accept -> o_submit; 1 instr/cycle while i_next_ready is held high.
// Backpressure: one-entry skid; o_ready (a flop) drops only once the skid is occupied.
// Ports: fetch side i_submit/i_instr/i_jmp_predict/o_ready; redirect i_flush/i_exec_pc;
// execute side o_submit/i_next_ready and the decoded fields/controls.
// DECODE_ILLEGAL_TRAP_EN adds o_illegal; otherwise undefined opcodes decode as NOP.
module decode
  import decode_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_submit,
  input  logic [I_SIZE-1:0] i_instr,
  input  logic              i_jmp_predict,
  output logic              o_ready,
  input  logic              i_flush,
  input  logic [RW-1:0]     i_exec_pc,
  output logic              o_submit,
  input  logic              i_next_ready,
  output logic [RW-1:0]     o_pc,
  output logic [OPC_W-1:0]  o_opcode,
  output logic [RSEL-1:0]   o_rd,
  output logic [RSEL-1:0]   o_rs1,
  output logic [RSEL-1:0]   o_rs2,
  output logic [COND_W-1:0] o_cond,
  output logic [RW-1:0]     o_imm,
  output logic              o_reg_we,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic              o_jump,
  output logic              o_jmp_predict
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic              o_illegal
`endif
);

  slot_state_t   state_q, state_d;
  dec_t          dec_in, out_q, skid_q;
  logic [RW-1:0] pc_cnt;
  logic          ready_q;
  logic          accept, transfer;
  logic          ld_out_in, ld_out_skid, ld_skid;

  assign accept   = i_submit & ready_q;
  assign transfer = (state_q != ST_EMPTY) & i_next_ready;

  decode_comb u_decode_comb (
    .instr       (i_instr),
    .pc          (pc_cnt),
    .jmp_predict (i_jmp_predict),
    .dec         (dec_in)
  );

  always_comb begin
    state_d     = state_q;
    ld_out_in   = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    if (i_flush) begin
      // A same-cycle submit is dropped; a same-cycle transfer is simply forgotten.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          ld_out_in = 1'b1;
          state_d   = ST_FULL;
        end
        ST_FULL: begin
          if (transfer && accept) begin
            ld_out_in = 1'b1;
          end else if (transfer) begin
            state_d = ST_EMPTY;
          end else if (accept) begin
            ld_skid = 1'b1;
            state_d = ST_SKID;
          end
        end
        // ready_q is low here, so no new instruction can arrive
        ST_SKID: if (transfer) begin
          ld_out_skid = 1'b1;
          state_d     = ST_FULL;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
      pc_cnt  <= '0;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      // Registered so fetch sees a clean flop; low exactly while the skid is full.
      ready_q <= (state_d != ST_SKID);
      if (i_flush)
        pc_cnt <= i_exec_pc;
      else if (accept)
        pc_cnt <= i_jmp_predict ? i_instr[IMM_LSB +: RW] : pc_cnt + RW'(1);
      if (ld_out_in)
        out_q <= dec_in;
      else if (ld_out_skid)
        out_q <= skid_q;
      if (ld_skid)
        skid_q <= dec_in;
    end
  end

  assign o_ready       = ready_q;
  assign o_submit      = (state_q != ST_EMPTY);
  assign o_pc          = out_q.pc;
  assign o_opcode      = out_q.opcode;
  assign o_rd          = out_q.rd;
  assign o_rs1         = out_q.rs1;
  assign o_rs2         = out_q.rs2;
  assign o_cond        = out_q.cond;
  assign o_imm         = out_q.imm;
  assign o_reg_we      = out_q.reg_we;
  assign o_mem_rd      = out_q.mem_rd;
  assign o_mem_wr      = out_q.mem_wr;
  assign o_jump        = out_q.jump;
  assign o_jmp_predict = out_q.jmp_predict;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign o_illegal     = out_q.illegal;
`endif

endmodule

// File: tb/tb_decode.sv
// tb_decode: table vectors, hand-written skid/flush/wrap sequences and a randomized
// run against a queue-based reference model of the decode stage.
module tb_decode;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_submit;
  logic [31:0] i_instr;
  logic        i_jmp_predict;
  logic        o_ready;
  logic        i_flush;
  logic [15:0] i_exec_pc;
  logic        o_submit;
  logic        i_next_ready;
  logic [15:0] o_pc;
  logic [6:0]  o_opcode;
  logic [2:0]  o_rd, o_rs1, o_rs2;
  logic [3:0]  o_cond;
  logic [15:0] o_imm;
  logic        o_reg_we, o_mem_rd, o_mem_wr, o_jump, o_jmp_predict;
  logic        dut_ill;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
  assign dut_ill = 1'b0;
`endif

  decode dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_submit      (i_submit),
    .i_instr       (i_instr),
    .i_jmp_predict (i_jmp_predict),
    .o_ready       (o_ready),
    .i_flush       (i_flush),
    .i_exec_pc     (i_exec_pc),
    .o_submit      (o_submit),
    .i_next_ready  (i_next_ready),
    .o_pc          (o_pc),
    .o_opcode      (o_opcode),
    .o_rd          (o_rd),
    .o_rs1         (o_rs1),
    .o_rs2         (o_rs2),
    .o_cond        (o_cond),
    .o_imm         (o_imm),
    .o_reg_we      (o_reg_we),
    .o_mem_rd      (o_mem_rd),
    .o_mem_wr      (o_mem_wr),
    .o_jump        (o_jump),
    .o_jmp_predict (o_jmp_predict)
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    .o_illegal     (dut_ill)
`endif
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  logic proto_err = 1'b0;

  // Fetch must never submit into a full decode stage (a flush makes it harmless).
  always @(posedge i_clk)
    if (i_rst === 1'b1 && i_submit && !o_ready && !i_flush) proto_err = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {6'b0, o_pc, o_opcode, o_rd, o_rs1, o_rs2, o_cond, o_imm,
            o_reg_we, o_mem_rd, o_mem_wr, o_jump, o_jmp_predict, dut_ill};
  endfunction

  // Reference decode: fields straight from the instruction layout, controls from the opcode table.
  function automatic logic [63:0] ref_vec(input logic [31:0] ins, input logic [15:0] pc, input logic p);
    int   op;
    logic we, mr, mw, j, il;
    op = int'(ins % 128);
    we = 1'b0; mr = 1'b0; mw = 1'b0; j = 1'b0; il = 1'b0;
    if (op >= 1 && op <= 13) we = 1'b1;
    else if (op == 14) j = 1'b1;
    else if (op == 15) begin j = 1'b1; we = 1'b1; end
    else if (op == 16) begin we = 1'b1; mr = 1'b1; end
    else if (op == 17) mw = 1'b1;
    else if (op == 18) we = 1'b1;
    else if (op != 0) il = TRAP;
    return {6'b0, pc, ins[6:0], ins[9:7], ins[12:10], ins[15:13], ins[10:7], ins[31:16],
            we, mr, mw, j, p, il};
  endfunction

  // Drive one cycle's inputs at the falling edge, then wait for the next falling edge.
  task automatic step(input logic s, input logic [31:0] ins, input logic p,
                      input logic nr, input logic f, input logic [15:0] epc);
    i_submit = s; i_instr = ins; i_jmp_predict = p;
    i_next_ready = nr; i_flush = f; i_exec_pc = epc;
    @(negedge i_clk);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        pred;
    logic [15:0] pc;
    logic [15:0] imm;
    logic [2:0]  rd;
    logic [3:0]  ctl;   // {reg_we, mem_rd, mem_wr, jump}
    logic        ill;
  } vec_t;

  vec_t vecs[12];
  logic [63:0] q[$];
  logic [15:0] mpc;

  initial begin
    vecs[0]  = '{32'h00050001, 1'b0, 16'h0000, 16'h0005, 3'd0, 4'b1000, 1'b0};
    vecs[1]  = '{32'h00000000, 1'b0, 16'h0001, 16'h0000, 3'd0, 4'b0000, 1'b0};
    vecs[2]  = '{32'h0000000d, 1'b0, 16'h0002, 16'h0000, 3'd0, 4'b1000, 1'b0};
    vecs[3]  = '{32'h0040000e, 1'b1, 16'h0003, 16'h0040, 3'd0, 4'b0001, 1'b0};
    vecs[4]  = '{32'h00000281, 1'b0, 16'h0040, 16'h0000, 3'd5, 4'b1000, 1'b0};
    vecs[5]  = '{32'h0000000f, 1'b0, 16'h0041, 16'h0000, 3'd0, 4'b1001, 1'b0};
    vecs[6]  = '{32'h00000390, 1'b0, 16'h0042, 16'h0000, 3'd7, 4'b1100, 1'b0};
    vecs[7]  = '{32'h00120011, 1'b0, 16'h0043, 16'h0012, 3'd0, 4'b0010, 1'b0};
    vecs[8]  = '{32'h00000012, 1'b0, 16'h0044, 16'h0000, 3'd0, 4'b1000, 1'b0};
    vecs[9]  = '{32'h0000007f, 1'b0, 16'h0045, 16'h0000, 3'd0, 4'b0000, TRAP};
    vecs[10] = '{32'h00000093, 1'b0, 16'h0046, 16'h0000, 3'd1, 4'b0000, TRAP};
    vecs[11] = '{32'hffff00ff, 1'b1, 16'h0047, 16'hffff, 3'd1, 4'b0000, TRAP};

    i_rst = 1'b0;
    i_submit = 1'b0; i_instr = '0; i_jmp_predict = 1'b0;
    i_next_ready = 1'b0; i_flush = 1'b0; i_exec_pc = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_submit", 64'(o_submit), 64'(0));
    chk("rst_ready",  64'(o_ready),  64'(1));
    chk("rst_fields", dut_vec(), 64'(0));
    i_rst = 1'b1;

    // Back-to-back table: one instruction per cycle, each visible the cycle after submit.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, vecs[i].instr, vecs[i].pred, 1'b1, 1'b0, 16'h0);
      chk($sformatf("tbl%0d", i),
          64'({o_submit, o_ready, o_pc, o_imm, o_rd, o_reg_we, o_mem_rd, o_mem_wr, o_jump,
               o_jmp_predict, dut_ill}),
          64'({1'b1, 1'b1, vecs[i].pc, vecs[i].imm, vecs[i].rd, vecs[i].ctl,
               vecs[i].pred, vecs[i].ill}));
      chk($sformatf("tbl%0d_full", i), dut_vec(),
          ref_vec(vecs[i].instr, vecs[i].pc, vecs[i].pred));
    end
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("tbl_drain", 64'(o_submit), 64'(0));

    // Skid: execute stalled, A then B accepted; A holds, then A and B drain in order.
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'h0200);
    chk("skid_flush", 64'({o_submit, o_ready}), 64'({1'b0, 1'b1}));
    step(1'b1, 32'h00000101, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("skid_a", 64'({o_submit, o_ready, o_pc, o_opcode}), 64'({1'b1, 1'b1, 16'h0200, 7'h01}));
    step(1'b1, 32'h00000182, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("skid_full", 64'({o_submit, o_ready, o_pc, o_opcode}), 64'({1'b1, 1'b0, 16'h0200, 7'h01}));
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("skid_hold", 64'({o_submit, o_ready, o_pc, o_opcode, o_rd}),
        64'({1'b1, 1'b0, 16'h0200, 7'h01, 3'd2}));
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("skid_b", 64'({o_submit, o_ready, o_pc, o_opcode, o_rd}),
        64'({1'b1, 1'b1, 16'h0201, 7'h02, 3'd3}));
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("skid_empty", 64'({o_submit, o_ready}), 64'({1'b0, 1'b1}));

    // Flush while in SKID with a simultaneous (dropped) submit.
    step(1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("fl_skid", 64'(o_ready), 64'(0));
    step(1'b1, 32'h00000004, 1'b0, 1'b0, 1'b1, 16'h0123);
    chk("fl_after", 64'({o_submit, o_ready}), 64'({1'b0, 1'b1}));
    step(1'b1, 32'h00000003, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("fl_next", 64'({o_submit, o_pc, o_opcode}), 64'({1'b1, 16'h0123, 7'h03}));
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'h0);

    // PC wrap at 0xFFFF.
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 16'hffff);
    step(1'b1, 32'h00000001, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("wrap_ffff", 64'({o_submit, o_pc}), 64'({1'b1, 16'hffff}));
    step(1'b1, 32'h00000005, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("wrap_0000", 64'({o_submit, o_pc}), 64'({1'b1, 16'h0000}));
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'h0);

    // Randomized traffic against the queue model (entries held = output slot + skid).
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'h0777);
    mpc = 16'h0777;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic        s, p, nr, f, xfer, acc;
      logic [31:0] ins;
      logic [15:0] epc;
      chk("rnd_vld", 64'(o_submit), 64'(q.size() > 0));
      chk("rnd_rdy", 64'(o_ready), 64'(q.size() < 2));
      if (q.size() > 0) chk("rnd_dat", dut_vec(), q[0]);
      f   = ($urandom_range(0, 39) == 0);
      s   = ($urandom_range(0, 2) != 0) && (q.size() < 2 || f);
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[6:0] = 7'($urandom_range(0, 18));
      p   = ($urandom_range(0, 3) == 0);
      nr  = ($urandom_range(0, 2) != 0);
      epc = 16'($urandom);
      xfer = (q.size() > 0) && nr;
      acc  = s && (q.size() < 2) && !f;
      if (f) begin
        q.delete();
        mpc = epc;
      end else begin
        if (xfer) void'(q.pop_front());
        if (acc) begin
          q.push_back(ref_vec(ins, mpc, p));
          mpc = p ? ins[31:16] : mpc + 16'd1;
        end
      end
      step(s, ins, p, nr, f, epc);
    end

    chk("protocol", 64'(proto_err), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- Instruction decode stage, directly downstream of instruction fetch and upstream of execute.
- Accepts one 32-bit instruction per handshake along with the fetch branch-prediction bit.
- Tracks the PC of every instruction. Splits it into register/immediate/control fields.
- Presents the result to execute through a registered valid/ready pipeline slot with a one-entry skid buffer, so o_ready is a flop output.

Parameters:
- RW, 16, machine word / PC width
- I_SIZE, 32, instruction width
- RSEL, 3, register-select width (8 GPRs)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-low (asserted when 0)
- i_submit  in  1  fetch presents a valid instruction this cycle (single-cycle pulse)
- i_instr  in  I_SIZE  instruction from fetch
- i_jmp_predict  in  1  fetch predicted taken for i_instr
- o_ready  out  1  decode can accept (drives fetch next-ready)
- i_flush  in  1  execute redirect; kill all in-flight state
- i_exec_pc  in  RW  corrected PC on flush
- o_submit  out  1  decoded instruction valid to execute
- i_next_ready  in  1  execute accepts this cycle
- o_pc  out  RW  PC of decoded instruction
- o_opcode  out  7  i_instr[6:0]
- o_rd, o_rs1, o_rs2  out  RSEL each  i_instr[9:7], [12:10], [15:13]
- o_cond  out  4  i_instr[10:7] (jump condition)
- o_imm  out  RW  i_instr[31:16]
- o_reg_we, o_mem_rd, o_mem_wr, o_jump  out  1 each  control class
- o_jmp_predict  out  1  registered copy of i_jmp_predict

Behaviour:
- Reset (i_rst==0, sampled at edge):
  - o_submit=0, skid empty, o_ready=1.
  - pc_cnt=0; all field/control outputs 0.
- Opcode classes:
  - 0x00 NOP: all controls 0.
  - 0x01..0x0d ALU: reg_we=1.
  - 0x0e JMP: jump=1.
  - 0x0f CALL: jump=1, reg_we=1.
  - 0x10 LD: reg_we=1, mem_rd=1.
  - 0x11 ST: mem_wr=1.
  - 0x12 SRS: reg_we=1.
  - Other opcodes: decoded as NOP (see optional feature).
- Input handshake: accept = i_submit & o_ready. An i_submit while o_ready=0 is a protocol violation; the bench asserts it never happens.
- PC tracking, on accept:
  - Instruction PC = pc_cnt.
  - pc_cnt <= i_jmp_predict ? i_instr[31:16] : pc_cnt+1.
  - pc_cnt wraps modulo 2^RW (0xFFFF+1 = 0).
- Output handshake: transfer = o_submit & i_next_ready. Outputs stay stable while o_submit=1 and i_next_ready=0.
- States:
  - EMPTY (o_submit=0):
    - On accept -> FULL; outputs loaded next cycle (1-cycle latency).
  - FULL (o_submit=1, skid empty):
    - transfer & accept: outputs reload, stay FULL.
    - transfer only -> EMPTY.
    - accept only -> SKID; the accepted instruction is decoded into the skid register; o_ready=0 from the next cycle.
  - SKID (o_ready=0):
    - On transfer: skid content moves to outputs -> FULL; o_ready=1 next cycle.
- Flush (highest priority after reset):
  - Next cycle: o_submit=0, skid empty, o_ready=1, pc_cnt <= i_exec_pc.
  - A same-cycle i_submit is dropped.
  - A same-cycle transfer still counts as consumed by execute; execute ignores it.
- Back-to-back throughput: 1 instr/cycle when i_next_ready is held 1.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- When defined:
  - Extra port o_illegal (out, 1), registered with the instruction.
  - Undefined opcodes set o_illegal=1 with all controls 0; execute raises an exception.
- When undefined:
  - The port is absent; undefined opcodes decode silently as NOP.

Decomposition:
- Shared package/config header holds RW, I_SIZE, RSEL, the opcode constants (OP_NOP, OP_JMP=0x0e, OP_CALL=0x0f, OP_LD, OP_ST, OP_SRS) and the field bit positions. Fetch and execute use the same header.
- One sub-module, decode_comb: purely combinational instruction -> fields/controls. It is instantiated once on the input path, and its result is loaded into either the output or the skid register.

Test Plan:
- Reset then submit 0x00050001 (ALU, imm 5) with i_next_ready=1 -> next cycle o_submit=1, o_pc=0, o_reg_we=1, o_imm=0x0005, o_rd=0.
- Submit JMP with imm 0x0040 and i_jmp_predict=1 at pc 3, then an ALU instruction -> second instruction o_pc=0x0040, o_jmp_predict=0.
- Hold i_next_ready=0, submit A then B -> o_ready=0 after B, outputs hold A; raise i_next_ready -> A, then B on consecutive cycles, o_ready=1.
- In SKID state assert i_flush with i_exec_pc=0x0123 and a simultaneous i_submit -> next cycle o_submit=0, o_ready=1; next accepted instruction has o_pc=0x0123.
- Set pc_cnt to 0xFFFF via flush, submit two non-jump instructions -> o_pc 0xFFFF then 0x0000.
- DECODE_ILLEGAL_TRAP_EN defined, submit opcode 0x7f -> o_illegal=1, o_reg_we=o_mem_rd=o_mem_wr=o_jump=0; undefined build -> plain NOP.
